// File: rtl/slice_serial_adder_if.sv
// Request/result bundle for slice_serial_adder.
// The master drives operands and control; the slave returns status and result.
interface slice_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             acc;
    logic             clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output start, sub, acc, clr, a, b, ci,
        input  busy, done, sum, co, ovf
    );

    modport slave (
        input  start, sub, acc, clr, a, b, ci,
        output busy, done, sum, co, ovf
    );
endinterface

// File: rtl/slice_serial_adder.sv
// Bit-serial-by-slice adder/subtractor: one SLICE-bit slice per clock, LSB first,
// carry registered between slices, optional accumulate of the previous result.
module slice_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    slice_serial_adder_if.slave bus
);
    localparam int unsigned NSL = WIDTH / SLICE;
    localparam int unsigned KW  = (NSL > 1) ? $clog2(NSL) : 1;

    if ((SLICE == 0) || (WIDTH % SLICE != 0)) begin : g_bad_param
        $error("WIDTH must be a non-zero multiple of SLICE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] sum_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic             co_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [SLICE:0]   slice_full;
    logic             slice_cmsb;
    logic [WIDTH-1:0] work_nxt;
    logic             last_slice;

    // Current slice: low SLICE bits of both shift registers plus the carry.
    always_comb begin
        slice_full = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]}
                   + (SLICE+1)'(carry_q);
        // Carry into the slice MSB recovered from the MSB's own sum bit.
        slice_cmsb = slice_full[SLICE-1] ^ a_q[SLICE-1] ^ b_q[SLICE-1];
        work_nxt   = WIDTH'({slice_full[SLICE-1:0], work_q} >> SLICE);
        last_slice = (k_q == KW'(NSL - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.acc ? sum_q : bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub | bus.ci;
                        k_q     <= '0;
                        work_q  <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                        if (bus.clr) begin
                            sum_q <= '0;
                            co_q  <= 1'b0;
                            ovf_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    work_q  <= work_nxt;
                    carry_q <= slice_full[SLICE];
                    k_q     <= k_q + KW'(1);
                    if (last_slice) begin
                        sum_q  <= work_nxt;
                        co_q   <= slice_full[SLICE];
                        ovf_q  <= slice_full[SLICE] ^ slice_cmsb;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;
endmodule
